// File: rtl/wb_ext_bridge.sv
// Wishbone classic slave to NS-target bridge: address-decoded fan-out, registered
// one-cycle responses, decode/target error, bus timeout and sticky error status.
module wb_ext_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NS      = 4,
  parameter int SELW    = 3,
  parameter int SEL_LSB = 12,
  parameter int TO_CYC  = 255,
  parameter int TO_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [DW/8-1:0]    wbs_sel_i,
  input  logic [AW-1:0]      wbs_adr_i,
  input  logic [DW-1:0]      wbs_dat_i,
  output logic               wbs_ack_o,
  output logic               wbs_err_o,
  output logic [DW-1:0]      wbs_dat_o,
  output logic [NS-1:0]      tgt_cyc_o,
  output logic [NS-1:0]      tgt_stb_o,
  output logic               tgt_we_o,
  output logic [DW/8-1:0]    tgt_sel_o,
  output logic [AW-1:0]      tgt_adr_o,
  output logic [DW-1:0]      tgt_dat_o,
  input  logic [NS*DW-1:0]   tgt_dat_i,
  input  logic [NS-1:0]      tgt_ack_i,
  input  logic [NS-1:0]      tgt_err_i,
  output logic               busy_o,
  output logic [1:0]         err_status_o,
  input  logic               err_clr_i,
  output logic [7:0]         tmo_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TO_CYC == 0) ? 0 : TO_CYC - 1);

  state_t            state, state_n;
  logic [TO_W-1:0]   cnt;
  logic [SELW-1:0]   adr_idx;
  logic [NS-1:0]     onehot;
  logic [DW-1:0]     rdata;
  logic              accept, dec_err, hit_ack, hit_err, tmo, drop, wait_cyc;

  assign adr_idx = wbs_adr_i[SEL_LSB +: SELW];
  assign busy_o  = (state != IDLE);

  // The one-hot strobe register doubles as the latched target index, so the
  // selected target's ack/err/data are picked by masking with it.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    dec_err  = 1'b0;
    hit_ack  = 1'b0;
    hit_err  = 1'b0;
    tmo      = 1'b0;
    drop     = 1'b0;
    wait_cyc = 1'b0;
    onehot   = '0;
    rdata    = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      onehot[k] = (32'(adr_idx) == k);
      if (tgt_stb_o[k]) rdata = tgt_dat_i[k*DW +: DW];
    end
    case (state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          accept = 1'b1;
          if (32'(adr_idx) >= NS) begin
            dec_err = 1'b1;
            state_n = RESP;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (!wbs_cyc_i) begin
          drop    = 1'b1;
          state_n = IDLE;
        end else if (|(tgt_err_i & tgt_stb_o)) begin
          hit_err = 1'b1;
          state_n = RESP;
        end else if (|(tgt_ack_i & tgt_stb_o)) begin
          hit_ack = 1'b1;
          state_n = RESP;
        end else if ((TO_CYC != 0) && (cnt == TO_LAST)) begin
          tmo     = 1'b1;
          state_n = RESP;
        end else begin
          wait_cyc = 1'b1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      wbs_ack_o    <= 1'b0;
      wbs_err_o    <= 1'b0;
      wbs_dat_o    <= '0;
      tgt_cyc_o    <= '0;
      tgt_stb_o    <= '0;
      tgt_we_o     <= 1'b0;
      tgt_sel_o    <= '0;
      tgt_adr_o    <= '0;
      tgt_dat_o    <= '0;
      err_status_o <= '0;
      tmo_cnt_o    <= '0;
    end else begin
      state     <= state_n;
      wbs_ack_o <= hit_ack;
      wbs_err_o <= hit_err | tmo | dec_err;
      if (accept) begin
        tgt_we_o  <= wbs_we_i;
        tgt_sel_o <= wbs_sel_i;
        tgt_adr_o <= wbs_adr_i;
        tgt_dat_o <= wbs_dat_i;
        tgt_cyc_o <= onehot;
        tgt_stb_o <= onehot;
        cnt       <= '0;
      end
      if (hit_ack || hit_err || tmo || drop) begin
        tgt_cyc_o <= '0;
        tgt_stb_o <= '0;
      end
      if (wait_cyc) cnt <= cnt + TO_W'(1);
      if (hit_ack && !tgt_we_o) wbs_dat_o <= rdata;
      err_status_o <= (err_clr_i ? 2'b00 : err_status_o) | {tmo, dec_err | hit_err};
      if (tmo && (tmo_cnt_o != 8'hFF)) tmo_cnt_o <= tmo_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_ext_bridge.sv
// Scoreboard bench for wb_ext_bridge: stimulus pushes expected responses and
// target requests into queues; monitors pop and compare as the DUT presents them.
module tb_wb_ext_bridge;

  localparam int AW = 32, DW = 32, NS = 4, TO_CYC = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]       wbs_sel_i = '0;
  logic [AW-1:0]    wbs_adr_i = '0;
  logic [DW-1:0]    wbs_dat_i = '0;
  logic             wbs_ack_o, wbs_err_o;
  logic [DW-1:0]    wbs_dat_o;
  logic [NS-1:0]    tgt_cyc_o, tgt_stb_o;
  logic             tgt_we_o;
  logic [3:0]       tgt_sel_o;
  logic [AW-1:0]    tgt_adr_o;
  logic [DW-1:0]    tgt_dat_o;
  logic [NS*DW-1:0] tgt_dat_i = '0;
  logic [NS-1:0]    tgt_ack_i = '0, tgt_err_i = '0;
  logic             busy_o;
  logic [1:0]       err_status_o;
  logic             err_clr_i = 1'b0;
  logic [7:0]       tmo_cnt_o;

  wb_ext_bridge #(.AW(AW), .DW(DW), .NS(NS), .SELW(3), .SEL_LSB(12), .TO_CYC(TO_CYC), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
    .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o), .tgt_we_o(tgt_we_o),
    .tgt_sel_o(tgt_sel_o), .tgt_adr_o(tgt_adr_o), .tgt_dat_o(tgt_dat_o),
    .tgt_dat_i(tgt_dat_i), .tgt_ack_i(tgt_ack_i), .tgt_err_i(tgt_err_i),
    .busy_o(busy_o), .err_status_o(err_status_o), .err_clr_i(err_clr_i),
    .tmo_cnt_o(tmo_cnt_o)
  );

  always #5 clk = ~clk;

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {logic err; int unsigned at; logic [31:0] dat; logic [1:0] st; logic [7:0] tc;} resp_t;
  typedef struct {logic [3:0] stb; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; logic we;} req_t;

  resp_t rq[$];
  req_t  qq[$];
  int    checks = 0, errors = 0;

  // Reference state: last read data, sticky status, timeout count.
  logic [31:0] m_dat = '0;
  logic [1:0]  m_st = '0;
  logic [7:0]  m_tc = '0;

  // Target behaviour: 0 ack, 1 err, 2 ack+err, 3 silent.
  int unsigned t_mode = 3, t_delay = 0;
  logic [31:0] t_rdata = '0;
  logic        noise = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Target model
  initial begin
    int unsigned w;
    w = 0;
    forever begin
      @(negedge clk);
      tgt_ack_i = '0;
      tgt_err_i = '0;
      for (int k = 0; k < NS; k++) tgt_dat_i[k*DW +: DW] = $urandom;
      if (tgt_stb_o == '0) w = 0;
      else begin
        for (int k = 0; k < NS; k++) begin
          if (tgt_stb_o[k]) begin
            tgt_dat_i[k*DW +: DW] = t_rdata;
            if (w == t_delay) begin
              tgt_ack_i[k] = (t_mode == 0) || (t_mode == 2);
              tgt_err_i[k] = (t_mode == 1) || (t_mode == 2);
            end
          end
        end
        w++;
      end
      if (noise) begin
        tgt_ack_i = tgt_ack_i | (4'($urandom) & ~tgt_stb_o);
        tgt_err_i = tgt_err_i | (4'($urandom) & ~tgt_stb_o);
      end
    end
  end

  // Monitors: host responses and target-side request fan-out
  initial begin
    resp_t r;
    req_t  q;
    logic [3:0] prev_stb;
    prev_stb = '0;
    forever begin
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o) begin
        if (rq.size() == 0) chk("resp_unexpected", 32'({wbs_ack_o, wbs_err_o}), 32'd0);
        else begin
          r = rq.pop_front();
          chk("resp_err", 32'(wbs_err_o), 32'(r.err));
          chk("resp_ack", 32'(wbs_ack_o), 32'(!r.err));
          chk("resp_cycle", cycle, r.at);
          chk("rdata", wbs_dat_o, r.dat);
          chk("err_status", 32'(err_status_o), 32'(r.st));
          chk("tmo_cnt", 32'(tmo_cnt_o), 32'(r.tc));
        end
      end
      if (tgt_stb_o != '0 && prev_stb == '0) begin
        if (qq.size() == 0) chk("req_unexpected", 32'(tgt_stb_o), 32'd0);
        else begin
          q = qq.pop_front();
          chk("tgt_stb", 32'(tgt_stb_o), 32'(q.stb));
          chk("tgt_cyc", 32'(tgt_cyc_o), 32'(q.stb));
          chk("tgt_adr", tgt_adr_o, q.adr);
          chk("tgt_dat", tgt_dat_o, q.dat);
          chk("tgt_sel", 32'(tgt_sel_o), 32'(q.sel));
          chk("tgt_we", 32'(tgt_we_o), 32'(q.we));
        end
      end
      prev_stb = tgt_stb_o;
    end
  end

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                      input logic [3:0] sel, input int unsigned mode, input int unsigned delay,
                      input logic [31:0] rd, input logic nz, input logic clr);
    int unsigned idx, lat, n;
    logic        iserr;
    logic [1:0]  setb;
    resp_t       r;
    req_t        q;
    @(negedge clk);
    idx = (adr >> 12) & 32'h7;
    if (idx >= NS) begin
      iserr = 1'b1; lat = 1; setb = 2'b01;
    end else if (mode != 3 && delay < TO_CYC) begin
      iserr = (mode != 0); lat = delay + 2; setb = iserr ? 2'b01 : 2'b00;
      if (!iserr && !we) m_dat = rd;
    end else begin
      iserr = 1'b1; lat = TO_CYC + 1; setb = 2'b10;
      if (m_tc != 8'hFF) m_tc = m_tc + 8'd1;
    end
    m_st = (clr ? 2'b00 : m_st) | setb;
    r.err = iserr; r.at = cycle + lat; r.dat = m_dat; r.st = m_st; r.tc = m_tc;
    rq.push_back(r);
    if (idx < NS) begin
      q.stb = 4'(1 << idx); q.adr = adr; q.dat = wd; q.sel = sel; q.we = we;
      qq.push_back(q);
    end
    t_mode = mode; t_delay = delay; t_rdata = rd; noise = nz;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = wd; wbs_sel_i = sel; err_clr_i = clr;
    n = 0;
    forever begin
      @(negedge clk);
      err_clr_i = 1'b0;
      if (wbs_ack_o || wbs_err_o) break;
      n++;
      if (n > 600) begin
        chk("resp_timeout", 32'({wbs_ack_o, wbs_err_o}), 32'(r.err ? 1 : 2));
        void'(rq.pop_front());
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    noise = 1'b0;
  endtask

  task automatic clr_status();
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    m_st = 2'b00;
    chk("status_clr", 32'(err_status_o), 32'(m_st));
  endtask

  task automatic start_silent(input logic [31:0] adr);
    req_t q;
    @(negedge clk);
    t_mode = 3; t_delay = 0; noise = 1'b0;
    q.stb = 4'(1 << ((adr >> 12) & 32'h7)); q.adr = adr; q.dat = 32'hA5A5_0001; q.sel = 4'h3; q.we = 1'b0;
    qq.push_back(q);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = adr; wbs_dat_i = 32'hA5A5_0001; wbs_sel_i = 4'h3;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned m, mode;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_err", 32'(wbs_err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cyc", 32'(tgt_cyc_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_status", 32'({tmo_cnt_o, err_status_o}), 32'd0);
    rst_n = 1'b1;

    xfer(1'b1, 32'h0000_2010, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0);
    xfer(1'b0, 32'h0000_3000, 32'h0, 4'hF, 0, 5, 32'h1234_5678, 1'b0, 1'b0);
    chk("cyc_released", 32'(tgt_cyc_o), 32'd0);
    xfer(1'b0, 32'h0000_5000, 32'h0, 4'hF, 0, 0, 32'h0, 1'b0, 1'b0);
    clr_status();
    xfer(1'b0, 32'h0000_1000, 32'h0, 4'hF, 3, 0, 32'h0, 1'b0, 1'b0);
    clr_status();
    xfer(1'b0, 32'h0000_0000, 32'h0, 4'hF, 2, 1, 32'hBAD0_BAD0, 1'b0, 1'b0);
    xfer(1'b0, 32'h0000_0004, 32'h0, 4'hF, 0, 3, 32'hCAFE_F00D, 1'b1, 1'b0);
    xfer(1'b0, 32'h0000_2020, 32'h0, 4'hF, 0, 254, 32'h0BAD_CAFE, 1'b0, 1'b0);
    xfer(1'b0, 32'h0000_2024, 32'h0, 4'hF, 0, 255, 32'h1111_2222, 1'b0, 1'b0);
    xfer(1'b1, 32'h0000_7000, 32'h5555_AAAA, 4'h1, 0, 0, 32'h0, 1'b0, 1'b1);

    start_silent(32'h0000_1040);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("drop_busy", 32'(busy_o), 32'd0);
    chk("drop_stb", 32'(tgt_stb_o), 32'd0);
    chk("drop_status", 32'(err_status_o), 32'(m_st));

    start_silent(32'h0000_2080);
    rst_n = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk);
    m_dat = '0; m_st = '0; m_tc = '0;
    chk("rstreq_cyc", 32'(tgt_cyc_o), 32'd0);
    chk("rstreq_stb", 32'(tgt_stb_o), 32'd0);
    chk("rstreq_resp", 32'({wbs_ack_o, wbs_err_o}), 32'd0);
    chk("rstreq_busy", 32'(busy_o), 32'd0);
    chk("rstreq_adr", tgt_adr_o, 32'd0);
    chk("rstreq_tmo", 32'(tmo_cnt_o), 32'(m_tc));
    rst_n = 1'b1;

    for (int i = 0; i < 60; i++) begin
      m = $urandom_range(0, 19);
      mode = (m < 12) ? 0 : (m < 16) ? 1 : (m < 19) ? 2 : 3;
      a = $urandom;
      a[14:12] = 3'($urandom_range(0, 7));
      xfer(1'($urandom), a, $urandom, 4'($urandom), mode, $urandom_range(0, 6), $urandom,
           1'($urandom), $urandom_range(0, 9) == 0);
    end

    repeat (3) @(negedge clk);
    chk("resp_queue_drained", rq.size(), 32'd0);
    chk("req_queue_drained", qq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
